// File: rtl/ece369_pipe_pkg.sv
// rtl/ece369_pipe_pkg.sv - shared state encodings and constants for the pipeline-stage registers
package ece369_pipe_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [STATE_W-1:0] ST_BUSY  = 2'd1;
  localparam logic [STATE_W-1:0] ST_FULL  = 2'd2;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Decode sees a live instruction in every occupied state.
  function automatic logic state_has_main(input logic [STATE_W-1:0] st);
    return (st == ST_BUSY) || (st == ST_FULL);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter shared by the pipeline-stage registers
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ifid_skid_stage.sv
// rtl/ifid_skid_stage.sv - IF/ID register as a two-entry skid buffer with flush-to-NOP and stall counter
module ifid_skid_stage
  import ece369_pipe_pkg::*;
#(
  parameter int                 PC_W        = 32,
  parameter int                 INSTR_W     = 32,
  parameter logic [INSTR_W-1:0] NOP_VAL     = INSTR_W'(MIPS_NOP),
  parameter int                 STALL_CNT_W = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Flush,
  input  logic                   In_Valid,
  output logic                   In_Ready,
  input  logic [PC_W-1:0]        In_PC,
  input  logic [INSTR_W-1:0]     In_Instr,
  output logic                   Out_Valid,
  input  logic                   Out_Ready,
  output logic [PC_W-1:0]        Out_PC,
  output logic [INSTR_W-1:0]     Out_Instr,
  output logic [STALL_CNT_W-1:0] Stall_Count
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;

  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               in_ready_q;

  logic in_xfer;
  logic out_xfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign Out_Valid = state_has_main(state);
  assign In_Ready  = in_ready_q;
  assign Out_PC    = main_pc;
  assign Out_Instr = main_instr;

  assign in_xfer  = In_Valid & in_ready_q;
  assign out_xfer = Out_Valid & Out_Ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          state_nxt    = ST_BUSY;
          load_main_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          state_nxt      = ST_BUSY;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // Flush leaves In_PC on the bubble so decode still sees a sensible PC.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= ST_EMPTY;
      main_pc    <= '0;
      main_instr <= NOP_VAL;
      skid_pc    <= '0;
      skid_instr <= '0;
      in_ready_q <= 1'b1;
    end else if (Flush) begin
      state      <= ST_EMPTY;
      main_pc    <= In_PC;
      main_instr <= NOP_VAL;
      skid_pc    <= '0;
      skid_instr <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
      if (load_main_in) begin
        main_pc    <= In_PC;
        main_instr <= In_Instr;
      end else if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (load_skid) begin
        skid_pc    <= In_PC;
        skid_instr <= In_Instr;
      end
    end
  end

  sat_counter #(
    .WIDTH(STALL_CNT_W)
  ) u_stall_cnt (
    .Clk  (Clk),
    .Rst  (Rst),
    .inc  (Out_Valid & ~Out_Ready & ~Flush),
    .count(Stall_Count)
  );

endmodule
